reg_file_sb: RTL and testbench

- Parametrised successor to the core integer register file: XLEN-wide, NREG-deep, NRP combinational read ports and one write port.
- Adds optional write-to-read bypass, a per-register pending scoreboard for in-flight destinations, and a sequenced bulk-clear engine with a ready handshake.
- Sits between decode/issue (reads, scoreboard set) and writeback (write, scoreboard clear). Register 0 is hardwired to zero.

---
 rtl/reg_file_pkg.sv | 22 ++
 rtl/reg_file_sb_if.sv | 37 +++
 rtl/reg_file_sb_clr_seq.sv | 68 ++++++
 rtl/reg_file_sb.sv | 97 +++++++++
 tb/tb_reg_file_sb.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_pkg
//  Purpose  : Shared defaults, clear-FSM encoding and port slicing helper.
//  Revision : 1.0
// ============================================================================
package reg_file_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb_if
//  Purpose  : Read / write / issue / clear bundle of the register file.
//  Revision : 1.0
// ============================================================================
interface reg_file_sb_if #(
  parameter int XLEN = reg_file_pkg::XLEN_DEF,
  parameter int NREG = reg_file_pkg::NREG_DEF,
  parameter int NRP  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]      rs_pending;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                wr_ready;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic                clr_req;
  logic                clr_busy;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, clr_req,
    input  rs_data, rs_pending, wr_ready, clr_busy
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, clr_req,
    output rs_data, rs_pending, wr_ready, clr_busy
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_sb_clr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_clr_seq
//  Purpose  : Bulk-clear sequencer, walks x1..x(NREG-1) one entry per cycle.
//  Revision : 1.0
// ============================================================================
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          clr_req_i,
  output logic               clr_busy_o,
  output logic               wr_ready_o,
  output logic               clr_we_o,
  output logic [AW-1:0]      clr_addr_o
);

  clr_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;
  logic          ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= AW'(1);
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          // Last entry is cleared in the same cycle the FSM heads home.
          if (ptr_q == AW'(NREG - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign clr_busy_o = busy_q;
  assign wr_ready_o = ready_q;
  assign clr_we_o   = busy_q;
  assign clr_addr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Purpose  : Integer register file with bypass, pending scoreboard, bulk clear.
//  Revision : 1.0
// ============================================================================
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRP    = 2,
  parameter bit BYPASS = 1'b1
) (
  input  wire logic     clk,
  input  wire logic     reset,
  reg_file_sb_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pend_q;

  logic            clr_busy;
  logic            wr_ready;
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            wr_fire;
  logic            iss_fire;

  reg_file_clr_seq #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clr_seq (
    .clk        (clk),
    .reset      (reset),
    .clr_req_i  (bus.clr_req),
    .clr_busy_o (clr_busy),
    .wr_ready_o (wr_ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign bus.clr_busy = clr_busy;
  assign bus.wr_ready = wr_ready;

  assign wr_fire  = bus.wr_en & wr_ready & (bus.wr_addr != '0);
  assign iss_fire = bus.iss_en & ~clr_busy & (bus.iss_rd != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr_fire) regs_q[bus.wr_addr] <= bus.wr_data;
      if (clr_we)  regs_q[clr_addr]    <= '0;
    end
  end

  // Issue is applied last so a same-cycle new producer keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      if (wr_fire)  pend_q[bus.wr_addr] <= 1'b0;
      if (clr_we)   pend_q[clr_addr]    <= 1'b0;
      if (iss_fire) pend_q[bus.iss_rd]  <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic [XLEN-1:0] data;

    assign addr = bus.rs_addr[slice_lo(p, AW) +: AW];

    if (BYPASS) begin : g_byp
      assign hit = wr_fire & (bus.wr_addr == addr);
    end else begin : g_nobyp
      assign hit = 1'b0;
    end

    always_comb begin
      data = regs_q[addr];
      if (addr == '0) data = '0;
      else if (hit)   data = bus.wr_data;
    end

    assign bus.rs_data[slice_lo(p, XLEN) +: XLEN] = data;
    assign bus.rs_pending[p] = pend_q[addr] & ~hit & (addr != '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_sb
//  Purpose  : Directed self-checking bench for reg_file_sb (BYPASS=1, NRP=2).
//  Revision : 1.0
// ============================================================================
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int XLEN = XLEN_DEF;
  localparam int NREG = NREG_DEF;
  localparam int NRP  = 2;
  localparam int AW   = $clog2(NREG);

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cnt;

  reg_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) bus ();

  reg_file_sb #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .NRP    (NRP),
    .BYPASS (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input int p, input int a);
    bus.rs_addr[p*AW +: AW] = AW'(a);
  endtask

  function automatic logic [63:0] rd(input int p);
    return 64'(bus.rs_data[p*XLEN +: XLEN]);
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.rs_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.iss_en  = 1'b0;
    bus.iss_rd  = '0;
    bus.clr_req = 1'b0;

    #3;
    check_eq("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    check_eq("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
    check_eq("rst_pending", 64'(bus.rs_pending), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // write x5 with same-cycle read on port 0 (bypass)
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 64'hDEAD_BEEF_0000_0001;
    set_rs(0, 5); set_rs(1, 0);
    #1;
    check_eq("byp_x5", rd(0), 64'hDEAD_BEEF_0000_0001);
    check_eq("x0_p1", rd(1), 64'd0);
    tick();
    bus.wr_en = 1'b0; set_rs(1, 5);
    #1;
    check_eq("rd_x5_p1", rd(1), 64'hDEAD_BEEF_0000_0001);

    // x0 protection
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = '1;
    set_rs(0, 0);
    #1;
    check_eq("x0_byp", rd(0), 64'd0);
    tick();
    bus.wr_en = 1'b0;
    bus.iss_en = 1'b1; bus.iss_rd = '0;
    tick();
    bus.iss_en = 1'b0;
    #1;
    check_eq("x0_rd", rd(0), 64'd0);
    check_eq("x0_pend", 64'(bus.rs_pending[0]), 64'd0);

    // normal issue then writeback on x7
    bus.iss_en = 1'b1; bus.iss_rd = 5'd7;
    tick();
    bus.iss_en = 1'b0; set_rs(0, 7);
    #1;
    check_eq("x7_pend", 64'(bus.rs_pending[0]), 64'd1);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h77;
    #1;
    check_eq("x7_wb_pend", 64'(bus.rs_pending[0]), 64'd0);
    check_eq("x7_wb_data", rd(0), 64'h77);
    tick();
    bus.wr_en = 1'b0;
    #1;
    check_eq("x7_pend_reg", 64'(bus.rs_pending[0]), 64'd0);
    check_eq("x7_data_reg", rd(0), 64'h77);

    // simultaneous issue and writeback on x7
    bus.iss_en = 1'b1; bus.iss_rd = 5'd7;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h99;
    tick();
    bus.iss_en = 1'b0; bus.wr_en = 1'b0;
    #1;
    check_eq("x7_same_pend", 64'(bus.rs_pending[0]), 64'd1);
    check_eq("x7_same_data", rd(0), 64'h99);

    // fill x1..x31 with their index, mark x9 pending
    for (int i = 1; i < NREG; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = 64'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    bus.iss_en = 1'b1; bus.iss_rd = 5'd9;
    tick();
    bus.iss_en = 1'b0;
    set_rs(0, 9); set_rs(1, 17);
    #1;
    check_eq("x9_pend_pre", 64'(bus.rs_pending[0]), 64'd1);
    check_eq("x17_fill", rd(1), 64'd17);

    // bulk clear
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.clr_busy) break;
      cnt++;
      check_eq("clr_wr_ready", 64'(bus.wr_ready), 64'd0);
      if (cnt == 1) begin
        set_rs(1, 31);
        #1;
        check_eq("clr_uncleared", rd(1), 64'd31);
      end
      if (cnt == 3) begin
        set_rs(1, 1);
        #1;
        check_eq("clr_cleared", rd(1), 64'd0);
      end
      if (cnt == 5) begin
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'hAA;
      end
      if (cnt == 6) bus.wr_en = 1'b0;
      if (cnt == 8) bus.clr_req = 1'b1;
      if (cnt == 9) bus.clr_req = 1'b0;
      if (cnt == 12) begin
        bus.iss_en = 1'b1; bus.iss_rd = 5'd2;
      end
      if (cnt == 13) bus.iss_en = 1'b0;
      tick();
    end
    check_eq("clr_cycles", 64'(cnt), 64'd31);
    check_eq("clr_done_ready", 64'(bus.wr_ready), 64'd1);
    for (int i = 0; i < NREG; i++) begin
      set_rs(0, i);
      #1;
      check_eq("clr_data", rd(0), 64'd0);
      check_eq("clr_pend", 64'(bus.rs_pending[0]), 64'd0);
    end

    // reset in the middle of a clear
    bus.wr_en = 1'b1; bus.wr_addr = 5'd20; bus.wr_data = 64'h20;
    tick();
    bus.wr_en = 1'b0;
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (9) tick();
    check_eq("mid_busy", 64'(bus.clr_busy), 64'd1);
    set_rs(0, 20);
    #1;
    check_eq("mid_x20", rd(0), 64'h20);
    reset = 1'b1;
    #1;
    check_eq("arst_busy", 64'(bus.clr_busy), 64'd0);
    check_eq("arst_ready", 64'(bus.wr_ready), 64'd1);
    check_eq("arst_x20", rd(0), 64'd0);
    #1;
    reset = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 64'h66;
    tick();
    bus.wr_en = 1'b0; set_rs(0, 6);
    #1;
    check_eq("post_rst_wr", rd(0), 64'h66);
    check_eq("post_rst_busy", 64'(bus.clr_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
